// File: rtl/avr_arb_pkg.sv
// Shared types and constants for the AVR data-memory arbiter.
package avr_arb_pkg;

  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  typedef enum logic {
    ARB_RUN  = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  // Wait-counter width; a disabled guard still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned max_wait);
    return (max_wait == 0) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/avr_arb_starve_ctr.sv
// Starvation guard: counts refused DMA cycles and forces a one-cycle CPU hold.
module avr_arb_starve_ctr
  import avr_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic hold
);

  localparam int unsigned CNT_W = cnt_width(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             refused;

  assign refused = dma_req && !dma_gnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ARB_RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Saturating refusal counter; any grant or dropped request restarts it.
  always_comb begin
    wcnt_d = wcnt_q;
    if (!refused) begin
      wcnt_d = '0;
    end else if (wcnt_q != CNT_MAX) begin
      wcnt_d = wcnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_RUN: begin
        if ((MAX_WAIT != 0) && refused && (wcnt_q == CNT_MAX - CNT_W'(1))) begin
          state_d = ARB_HOLD;
        end
      end
      ARB_HOLD: state_d = ARB_RUN;
      default:  state_d = ARB_RUN;
    endcase
  end

  always_comb begin
    hold = 1'b0;
    if (state_q == ARB_HOLD) begin
      hold = 1'b1;
    end
  end

endmodule

// File: rtl/avr_dmem_arbiter.sv
// Single-port data SRAM arbiter: CPU has fixed priority, DMA gets idle slots
// plus a guaranteed slot via cpu_hold. Define ARB_STATS_EN for grant counters.
module avr_dmem_arbiter
  import avr_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hold,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_cpu,
  output logic [STAT_W-1:0] stat_dma,
  output logic [STAT_W-1:0] stat_hold
`endif
);

  owner_t            owner, owner_q;
  logic              was_read_q;
  logic              hold;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

  avr_arb_starve_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .dma_req(dma_req),
    .dma_gnt(dma_gnt),
    .hold   (hold)
  );

  // Owner selection; reset forces the bus idle so every output reads 0.
  always_comb begin
    owner = OWN_NONE;
    if (!RST_N) begin
      owner = OWN_NONE;
    end else if (hold) begin
      owner = dma_req ? OWN_DMA : OWN_NONE;
    end else if (cpu_req) begin
      owner = OWN_CPU;
    end else if (dma_req) begin
      owner = OWN_DMA;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (owner)
      OWN_CPU: begin
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      OWN_DMA: begin
        mem_en    = 1'b1;
        mem_we    = dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

  assign dma_gnt  = (owner == OWN_DMA);
  assign cpu_hold = hold;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      owner_q     <= OWN_NONE;
      was_read_q  <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      owner_q     <= owner;
      was_read_q  <= mem_en && !mem_we;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  // Route returning read data to whoever issued it; the CPU bus keeps its last value otherwise.
  always_comb begin
    dma_rvalid  = (owner_q == OWN_DMA) && was_read_q;
    dma_rdata   = dma_rvalid ? mem_rdata : '0;
    cpu_rdata_d = cpu_rdata_q;
    if ((owner_q == OWN_CPU) && was_read_q) begin
      cpu_rdata_d = mem_rdata;
    end
    cpu_rdata = cpu_rdata_d;
  end

`ifdef ARB_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [STAT_W-1:0] stat_cpu_q, stat_cpu_d;
  logic [STAT_W-1:0] stat_dma_q, stat_dma_d;
  logic [STAT_W-1:0] stat_hold_q, stat_hold_d;

  always_comb begin
    stat_cpu_d  = stat_cpu_q;
    stat_dma_d  = stat_dma_q;
    stat_hold_d = stat_hold_q;
    if ((owner == OWN_CPU) && (stat_cpu_q != STAT_MAX)) begin
      stat_cpu_d = stat_cpu_q + STAT_W'(1);
    end
    if ((owner == OWN_DMA) && (stat_dma_q != STAT_MAX)) begin
      stat_dma_d = stat_dma_q + STAT_W'(1);
    end
    if (hold && (stat_hold_q != STAT_MAX)) begin
      stat_hold_d = stat_hold_q + STAT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stat_cpu_q  <= '0;
      stat_dma_q  <= '0;
      stat_hold_q <= '0;
    end else begin
      stat_cpu_q  <= stat_cpu_d;
      stat_dma_q  <= stat_dma_d;
      stat_hold_q <= stat_hold_d;
    end
  end

  assign stat_cpu  = stat_cpu_q;
  assign stat_dma  = stat_dma_q;
  assign stat_hold = stat_hold_q;
`endif

endmodule

// File: tb/tb_avr_dmem_arbiter.sv
// Directed bench for avr_dmem_arbiter: MAX_WAIT=8 instance plus a MAX_WAIT=0 instance.
module tb_avr_dmem_arbiter;
  import avr_arb_pkg::*;

  logic        CLK;
  logic        RST_N;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata;

  logic [7:0]  cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic        cpu_hold, dma_gnt, dma_rvalid, mem_en, mem_we;
  logic [15:0] mem_addr;

  logic [7:0]  cpu_rdata_z, dma_rdata_z, mem_wdata_z, mem_rdata_z;
  logic        cpu_hold_z, dma_gnt_z, dma_rvalid_z, mem_en_z, mem_we_z;
  logic [15:0] mem_addr_z;

  logic [7:0]  ram8 [0:65535];
  logic [7:0]  ram0 [0:65535];

  int n_checks = 0;
  int n_pass   = 0;

  avr_dmem_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(8)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  avr_dmem_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(0)) dut0 (
    .CLK(CLK), .RST_N(RST_N),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata_z), .cpu_hold(cpu_hold_z),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt_z), .dma_rvalid(dma_rvalid_z), .dma_rdata(dma_rdata_z),
    .mem_en(mem_en_z), .mem_we(mem_we_z), .mem_addr(mem_addr_z), .mem_wdata(mem_wdata_z),
    .mem_rdata(mem_rdata_z)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One-cycle-latency single-port RAM per instance.
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) ram8[mem_addr] <= mem_wdata;
      mem_rdata <= ram8[mem_addr];
    end
  end

  always @(posedge CLK) begin
    if (mem_en_z) begin
      if (mem_we_z) ram0[mem_addr_z] <= mem_wdata_z;
      mem_rdata_z <= ram0[mem_addr_z];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    next_cycle();
    idle_inputs();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
  endtask

  initial begin
    RST_N = 1'b0;
    mem_rdata = '0;
    mem_rdata_z = '0;
    idle_inputs();

    // Reset held with random inputs: every output reads 0.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      cpu_req = 1'($urandom); cpu_we = 1'($urandom);
      cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
      dma_req = 1'($urandom); dma_we = 1'($urandom);
      dma_addr = 16'($urandom); dma_wdata = 8'($urandom);
      @(negedge CLK);
      chk("rst_outputs", {mem_en, mem_we, mem_addr, mem_wdata, dma_gnt, dma_rvalid,
                          dma_rdata, cpu_rdata, cpu_hold}, 64'd0);
    end

    next_cycle();
    idle_inputs();
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rel_state", 64'(dut.u_starve.state_q), 64'(ARB_RUN));
    chk("rel_wcnt", 64'(dut.u_starve.wcnt_q), 64'd0);
    chk("rel_idle", {mem_en, dma_gnt, cpu_hold}, 64'd0);

    // Seed RAM through CPU writes.
    cpu_write(16'h0100, 8'hA5);
    @(negedge CLK);
    chk("cpu_wr_bus", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 16'h0100, 8'hA5});
    cpu_write(16'h0101, 8'h5A);
    cpu_write(16'h0300, 8'h77);
    next_cycle();
    idle_inputs();
    @(negedge CLK);
    chk("wr_no_resp", {dma_rvalid, cpu_rdata}, 64'd0);

    // CPU-only read.
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    @(negedge CLK);
    chk("cpu_rd_bus", {mem_en, mem_we, mem_addr, dma_gnt}, {2'b10, 16'h0100, 1'b0});
    next_cycle();
    idle_inputs();
    @(negedge CLK);
    chk("cpu_rd_data", cpu_rdata, 8'hA5);
    chk("cpu_rd_no_dvalid", dma_rvalid, 1'b0);
    next_cycle();
    @(negedge CLK);
    chk("cpu_rd_hold", cpu_rdata, 8'hA5);

    // Idle-slot DMA write then read.
    next_cycle();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0200; dma_wdata = 8'h3C;
    @(negedge CLK);
    chk("dma_wr_gnt", {dma_gnt, mem_we, mem_addr, mem_wdata}, {2'b11, 16'h0200, 8'h3C});
    next_cycle();
    dma_we = 1'b0;
    @(negedge CLK);
    chk("dma_rd_gnt", {dma_gnt, mem_we, dma_rvalid}, 3'b100);
    next_cycle();
    idle_inputs();
    @(negedge CLK);
    chk("dma_rd_ret", {dma_rvalid, dma_rdata}, {1'b1, 8'h3C});
    chk("dma_rd_not_cpu", cpu_rdata, 8'hA5);
    next_cycle();
    @(negedge CLK);
    chk("dma_rvalid_drop", dma_rvalid, 1'b0);

    // Starvation: CPU busy every cycle, DMA read of 0x0300 pending.
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0101;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0300;
      @(negedge CLK);
      chk("starve_refused", {cpu_hold, dma_gnt, mem_addr}, {2'b00, 16'h0101});
      chk("starve_wcnt", 64'(dut.u_starve.wcnt_q), 64'(k));
      if (k == 0) chk("starve_rdata0", cpu_rdata, 8'hA5);
      if (k == 1) chk("starve_rdata1", cpu_rdata, 8'h5A);
    end
    next_cycle();
    @(negedge CLK);
    chk("hold_cycle", {cpu_hold, dma_gnt, mem_addr}, {2'b11, 16'h0300});
    chk("hold_cpu_ret", cpu_rdata, 8'h5A);
    next_cycle();
    dma_req = 1'b0;
    @(negedge CLK);
    chk("after_hold", {cpu_hold, dma_gnt, mem_addr}, {2'b00, 16'h0101});
    chk("after_hold_wcnt", 64'(dut.u_starve.wcnt_q), 64'd0);
    chk("hold_dma_ret", {dma_rvalid, dma_rdata}, {1'b1, 8'h77});
    chk("hold_cpu_kept", cpu_rdata, 8'h5A);
    next_cycle();
    idle_inputs();
    @(negedge CLK);
    chk("post_hold_cpu", {dma_rvalid, cpu_rdata}, {1'b0, 8'h5A});

    // MAX_WAIT=0 instance: DMA only in idle CPU cycles.
    for (int k = 0; k < 100; k++) begin
      next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0101;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0200;
      @(negedge CLK);
      chk("mw0_no_hold", cpu_hold_z, 1'b0);
      chk("mw0_no_gnt", dma_gnt_z, 1'b0);
    end
    next_cycle();
    cpu_req = 1'b0;
    @(negedge CLK);
    chk("mw0_gnt_idle", {dma_gnt_z, cpu_hold_z}, 2'b10);
    next_cycle();
    idle_inputs();
    @(negedge CLK);
    chk("mw0_dma_ret", {dma_rvalid_z, dma_rdata_z}, {1'b1, 8'h3C});
    next_cycle();
    next_cycle();

    // Reset arriving the cycle after a DMA read grant.
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0200;
    @(negedge CLK);
    chk("mid_rd_gnt", dma_gnt, 1'b1);
    next_cycle();
    RST_N = 1'b0;
    idle_inputs();
    #1;
    chk("mid_rd_rst_now", {dma_rvalid, dma_rdata}, 64'd0);
    @(negedge CLK);
    chk("mid_rd_rst_neg", {dma_rvalid, dma_rdata, cpu_rdata}, 64'd0);
    next_cycle();
    RST_N = 1'b1;
    @(negedge CLK);
    chk("mid_rd_release", {dma_rvalid, cpu_hold, mem_en}, 64'd0);
    chk("mid_rd_state", 64'(dut.u_starve.state_q), 64'(ARB_RUN));
    next_cycle();
    @(negedge CLK);
    chk("mid_rd_stay", dma_rvalid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
